// File: rtl/tlul_host_adapter_pkg.sv
// Types and helpers local to the TL-UL host adapter: the reorder-slot record and
// the a_source slot-index width.
package tlul_host_adapter_pkg;

    typedef struct packed {
        logic        busy;
        logic        filled;
        logic        is_write;
        logic        err;
        logic [31:0] data;
    } slot_t;

    // Slot-index width for a given outstanding depth, never narrower than 1 bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by hosts and devices: host-to-device and device-to-host
// channel structs, A/D opcodes, the default A-channel user field and the
// command/data integrity generators.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [3:0] MuBi4True  = 4'h6;
    localparam logic [3:0] MuBi4False = 4'h9;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '{
        instr_type: MuBi4False,
        cmd_intg:   7'h00,
        data_intg:  7'h00
    };

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Folds a vector into 7 check bits; bit i contributes to check bit i mod 7.
    function automatic logic [6:0] intg_fold(input logic [63:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i % 7] = r[i % 7] ^ v[i];
        end
        return r;
    endfunction

    function automatic logic [6:0] cmd_intg_gen(input tl_a_op_e op, input logic [31:0] addr,
                                                input logic [3:0] mask,
                                                input logic [3:0] instr_type);
        return intg_fold({21'h0, instr_type, addr, 3'(op), mask});
    endfunction

    function automatic logic [6:0] data_intg_gen(input logic [31:0] data);
        return intg_fold({32'h0, data});
    endfunction

endpackage

// File: rtl/tlul_host_adapter_if.sv
// Local req/gnt/rvalid memory port between a simple master and the TL-UL host
// adapter. master: the initiator (drives req and request fields, takes gnt and
// responses). slave: the adapter side.
interface tlul_host_adapter_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        instr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be, instr,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be, instr,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/tlul_host_rob.sv
// Reorder buffer of the TL-UL host adapter. Allocates one slot per granted
// request, fills slots from D-channel beats by source index, and retires slots in
// allocation order as one-cycle response pulses.
// Ports: alloc_i/alloc_write_i/alloc_idx_o/full_o (allocation side),
// d_valid_i/d_source_i/d_data_i/d_error_i (D beat), rvalid_o/rdata_o/err_o
// (in-order response), unexp_rsp_o (sticky unexpected-source flag).
module tlul_host_rob
    import tlul_host_adapter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned SourceBase     = 0,
    localparam int unsigned SrcW          = src_w(MaxOutstanding)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alloc_i,
    input  logic            alloc_write_i,
    output logic [SrcW-1:0] alloc_idx_o,
    output logic            full_o,
    input  logic            d_valid_i,
    input  logic [7:0]      d_source_i,
    input  logic [31:0]     d_data_i,
    input  logic            d_error_i,
    output logic            rvalid_o,
    output logic [31:0]     rdata_o,
    output logic            err_o,
    output logic            unexp_rsp_o
);
    // Array covers every index value so d_source decoding never goes out of range.
    localparam int unsigned Slots = 1 << SrcW;
    localparam int unsigned CntW  = SrcW + 1;

    slot_t           slots_q [Slots];
    slot_t           slots_d [Slots];
    logic [SrcW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [SrcW-1:0] retire_ptr_q, retire_ptr_d;
    logic [CntW-1:0] used_q, used_d;
    logic            unexp_q, unexp_d;
    logic [SrcW-1:0] d_idx;
    logic            d_match;
    logic            retire;
    slot_t           head;

    function automatic logic [SrcW-1:0] wrap_inc(input logic [SrcW-1:0] p);
        return (32'(p) == MaxOutstanding - 1) ? '0 : p + SrcW'(1);
    endfunction

    assign d_idx   = d_source_i[SrcW-1:0];
    assign head    = slots_q[retire_ptr_q];
    assign retire  = head.filled;
    assign d_match = (d_source_i == (8'(SourceBase) | 8'(d_idx)))
                     && (32'(d_idx) < MaxOutstanding)
                     && slots_q[d_idx].busy && !slots_q[d_idx].filled;

    assign alloc_idx_o = alloc_ptr_q;
    assign full_o      = (32'(used_q) >= MaxOutstanding);
    assign rvalid_o    = retire;
    assign rdata_o     = retire ? head.data : 32'h0;
    assign err_o       = retire & head.err;
    assign unexp_rsp_o = unexp_q;

    always_comb begin
        slots_d      = slots_q;
        alloc_ptr_d  = alloc_ptr_q;
        retire_ptr_d = retire_ptr_q;
        unexp_d      = unexp_q;
        used_d       = used_q + CntW'(alloc_i) - CntW'(retire);

        if (retire) begin
            slots_d[retire_ptr_q].busy   = 1'b0;
            slots_d[retire_ptr_q].filled = 1'b0;
            retire_ptr_d                 = wrap_inc(retire_ptr_q);
        end

        // A retiring slot is already filled, so a beat for it is unexpected.
        if (d_valid_i) begin
            if (d_match) begin
                slots_d[d_idx].filled = 1'b1;
                slots_d[d_idx].err    = d_error_i;
                slots_d[d_idx].data   = slots_q[d_idx].is_write ? 32'h0 : d_data_i;
            end else begin
                unexp_d = 1'b1;
            end
        end

        // The slot at alloc_ptr is free whenever a grant is possible.
        if (alloc_i) begin
            slots_d[alloc_ptr_q] = '{busy: 1'b1, filled: 1'b0, is_write: alloc_write_i,
                                     err: 1'b0, data: 32'h0};
            alloc_ptr_d          = wrap_inc(alloc_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Slots; i++) begin
                slots_q[i] <= '0;
            end
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            used_q       <= '0;
            unexp_q      <= 1'b0;
        end else begin
            slots_q      <= slots_d;
            alloc_ptr_q  <= alloc_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            used_q       <= used_d;
            unexp_q      <= unexp_d;
        end
    end

endmodule

// File: rtl/tlul_host_adapter.sv
// Generic TL-UL initiator. Turns a req/gnt/rvalid memory port into TL-UL A-channel
// requests and returns D-channel responses to the master in issue order.
// Ports: clk_i/rst_i (synchronous active-high reset), mem (local port, slave side),
// unexp_rsp_o (sticky: D beat for a source not outstanding), tl_o/tl_i (TL-UL).
module tlul_host_adapter
    import tlul_pkg::*;
    import tlul_host_adapter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned SourceBase     = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tlul_host_adapter_if.slave mem,
    output logic               unexp_rsp_o,
    output tl_h2d_t            tl_o,
    input  tl_d2h_t            tl_i
);
    localparam int unsigned SrcW = src_w(MaxOutstanding);

    logic            full;
    logic [SrcW-1:0] alloc_idx;
    logic            grant;
    tl_a_op_e        opcode_enc;

    logic            a_pending_q;
    tl_a_op_e        a_opcode_q;
    logic [3:0]      a_mask_q;
    logic [29:0]     a_word_q;
    logic [SrcW-1:0] a_slot_q;
    logic [31:0]     a_data_q;
    logic            a_instr_q;

    logic            unused_in;
    assign unused_in = ^{mem.addr[1:0], 3'(tl_i.d_opcode), tl_i.d_size};

    // Grant depends only on registered state, never on a_ready or this cycle's retire.
    assign grant   = mem.req & ~a_pending_q & ~full;
    assign mem.gnt = grant;

    always_comb begin
        if (!mem.we) begin
            opcode_enc = Get;
        end else if (mem.be == 4'hF) begin
            opcode_enc = PutFullData;
        end else begin
            opcode_enc = PutPartialData;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_pending_q <= 1'b0;
            a_opcode_q  <= Get;
            a_mask_q    <= 4'h0;
            a_word_q    <= '0;
            a_slot_q    <= '0;
            a_data_q    <= 32'h0;
            a_instr_q   <= 1'b0;
        end else if (grant) begin
            a_pending_q <= 1'b1;
            a_opcode_q  <= opcode_enc;
            a_mask_q    <= mem.we ? mem.be : 4'hF;
            a_word_q    <= mem.addr[31:2];
            a_slot_q    <= alloc_idx;
            a_data_q    <= mem.we ? mem.wdata : 32'h0;
            a_instr_q   <= mem.instr;
        end else if (tl_i.a_ready) begin
            a_pending_q <= 1'b0;
        end
    end

    always_comb begin
        tl_o                   = '0;
        tl_o.a_valid           = a_pending_q;
        tl_o.a_opcode          = a_opcode_q;
        tl_o.a_size            = 2'd2;
        tl_o.a_source          = 8'(SourceBase) | 8'(a_slot_q);
        tl_o.a_address         = {a_word_q, 2'b00};
        tl_o.a_mask            = a_mask_q;
        tl_o.a_data            = a_data_q;
        tl_o.a_user            = TL_A_USER_DEFAULT;
        tl_o.a_user.instr_type = a_instr_q ? MuBi4True : MuBi4False;
        tl_o.a_user.cmd_intg   = cmd_intg_gen(a_opcode_q, {a_word_q, 2'b00}, a_mask_q,
                                              tl_o.a_user.instr_type);
        tl_o.a_user.data_intg  = data_intg_gen(a_data_q);
        tl_o.d_ready           = 1'b1;
    end

    tlul_host_rob #(
        .MaxOutstanding(MaxOutstanding),
        .SourceBase    (SourceBase)
    ) u_rob (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alloc_i      (grant),
        .alloc_write_i(mem.we),
        .alloc_idx_o  (alloc_idx),
        .full_o       (full),
        .d_valid_i    (tl_i.d_valid),
        .d_source_i   (tl_i.d_source),
        .d_data_i     (tl_i.d_data),
        .d_error_i    (tl_i.d_error),
        .rvalid_o     (mem.rvalid),
        .rdata_o      (mem.rdata),
        .err_o        (mem.err),
        .unexp_rsp_o  (unexp_rsp_o)
    );

endmodule
